// File: rtl/wisc_pkg.sv
// Shared definitions for the 16-bit WISC core.
// Opcodes, flag bit positions, default widths, halt FSM states.
package wisc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 4;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  // flags vector is {Z,V,N}
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_st_t;

endpackage

// File: rtl/ex_mem_stage_flag_reg.sv
// Architectural {Z,V,N} flag register.
// Three async-reset flops, each with its own write enable.
module flag_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] wen,
  input  logic [2:0] d,
  output logic [2:0] q
);

  // Per-bit load so logical ops can update Z alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (wen[i]) q[i] <= d[i];
      end
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with flag register and halt sequencing.
// HLT drains MEM+WB, then raises a sticky halted until reset.
module ex_mem_stage
  import wisc_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_AW    = REG_AW_DEF,
  parameter int DRAIN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_ovfl,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  output logic              mem_valid,
  output logic [3:0]        mem_opcode,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_rd_addr,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [2:0]        flags,
  output logic              halted
);

  localparam int CNT_W = $clog2(DRAIN_CYC + 1);

  halt_st_t         state;
  halt_st_t         state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             take;
  logic             is_hlt;
  logic [2:0]       flag_en;
  logic [2:0]       flag_d;

  // An instruction is really captured only in RUN, unstalled, unflushed.
  assign take   = !stall && !flush && ex_valid
                  && (state == RUN);
  assign is_hlt = (ex_opcode == OP_HLT);
  assign halted = (state == HALTED);

  // Halt sequencing: next state and drain count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!stall) begin
      unique case (state)
        RUN: begin
          if (take && is_hlt) begin
            state_nxt = DRAIN;
            cnt_nxt   = CNT_W'(DRAIN_CYC - 1);
          end
        end
        DRAIN: begin
          if (cnt == '0) state_nxt = HALTED;
          else           cnt_nxt   = cnt - CNT_W'(1);
        end
        HALTED: state_nxt = HALTED;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Halt FSM state and drain counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Pipeline fields; control gated by capture, HLT never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_opcode     <= '0;
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_rd_addr    <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= take;
      mem_opcode     <= ex_opcode;
      mem_result     <= ex_result;
      mem_store_data <= ex_store_data;
      mem_rd_addr    <= ex_rd_addr;
      mem_reg_write  <= take && ex_reg_write && !is_hlt;
      mem_mem_read   <= take && ex_mem_read && !is_hlt;
      mem_mem_write  <= take && ex_mem_write && !is_hlt;
    end
  end

  // Flag write enables: ADD/SUB set all, logic/shift set Z only.
  always_comb begin
    flag_en         = 3'b000;
    flag_d          = 3'b000;
    flag_d[FLAG_Z]  = (ex_result == '0);
    flag_d[FLAG_V]  = ex_ovfl;
    flag_d[FLAG_N]  = ex_result[DATA_W-1];
    if (take) begin
      unique case (1'b1)
        (ex_opcode == OP_ADD),
        (ex_opcode == OP_SUB): flag_en = 3'b111;
        (ex_opcode == OP_XOR),
        (ex_opcode == OP_SLL),
        (ex_opcode == OP_SRA),
        (ex_opcode == OP_ROR): flag_en[FLAG_Z] = 1'b1;
        default: flag_en = 3'b000;
      endcase
    end
  end

  flag_reg u_flag_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (flag_en),
    .d     (flag_d),
    .q     (flags)
  );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage.
// Directed vectors, behavioural model, literal spot checks.
module tb_ex_mem_stage;
  import wisc_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          ex_valid = 1'b0;
  logic [3:0]    ex_opcode = '0;
  logic [DW-1:0] ex_result = '0;
  logic          ex_ovfl = 1'b0;
  logic [DW-1:0] ex_store_data = '0;
  logic [AW-1:0] ex_rd_addr = '0;
  logic          ex_reg_write = 1'b0;
  logic          ex_mem_read = 1'b0;
  logic          ex_mem_write = 1'b0;

  logic          mem_valid;
  logic [3:0]    mem_opcode;
  logic [DW-1:0] mem_result;
  logic [DW-1:0] mem_store_data;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_reg_write;
  logic          mem_mem_read;
  logic          mem_mem_write;
  logic [2:0]    flags;
  logic          halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(
    .DATA_W(DW), .REG_AW(AW), .DRAIN_CYC(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_result(ex_result), .ex_ovfl(ex_ovfl),
    .ex_store_data(ex_store_data),
    .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .mem_valid(mem_valid), .mem_opcode(mem_opcode),
    .mem_result(mem_result),
    .mem_store_data(mem_store_data),
    .mem_rd_addr(mem_rd_addr),
    .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write),
    .flags(flags), .halted(halted)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Behavioural model: halt is "seen" once, halted after DC live cycles.
  logic          m_valid, m_rw, m_mr, m_mw;
  logic [3:0]    m_op;
  logic [DW-1:0] m_res, m_sd;
  logic [AW-1:0] m_rd;
  logic          m_z, m_v, m_n;
  logic          m_hlt_seen;
  int            m_since;

  wire m_accept = ex_valid && !flush && !m_hlt_seen;
  wire m_hlt    = (ex_opcode == OP_HLT);
  wire m_arith  = ex_opcode inside {OP_ADD, OP_SUB};
  wire m_zonly  = ex_opcode inside {OP_XOR, OP_SLL,
                                    OP_SRA, OP_ROR};
  wire m_halted = m_hlt_seen && (m_since >= DC);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_rw <= 0; m_mr <= 0; m_mw <= 0;
      m_op <= '0; m_res <= '0; m_sd <= '0; m_rd <= '0;
      m_z <= 0; m_v <= 0; m_n <= 0;
      m_hlt_seen <= 0; m_since <= 0;
    end else if (!stall) begin
      m_valid <= m_accept;
      m_rw    <= m_accept && ex_reg_write && !m_hlt;
      m_mr    <= m_accept && ex_mem_read && !m_hlt;
      m_mw    <= m_accept && ex_mem_write && !m_hlt;
      m_op    <= ex_opcode;
      m_res   <= ex_result;
      m_sd    <= ex_store_data;
      m_rd    <= ex_rd_addr;
      if (m_accept && m_hlt) m_hlt_seen <= 1;
      if (m_hlt_seen && m_since < DC)
        m_since <= m_since + 1;
      if (m_accept && (m_arith || m_zonly))
        m_z <= (ex_result == 0);
      if (m_accept && m_arith) begin
        m_v <= ex_ovfl;
        m_n <= ex_result[DW-1];
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("valid", 32'(mem_valid), 32'(m_valid));
    chk("reg_write", 32'(mem_reg_write), 32'(m_rw));
    chk("mem_read", 32'(mem_mem_read), 32'(m_mr));
    chk("mem_write", 32'(mem_mem_write), 32'(m_mw));
    chk("flags", 32'(flags), 32'({m_z, m_v, m_n}));
    chk("halted", 32'(halted), 32'(m_halted));
    if (m_valid) begin
      chk("opcode", 32'(mem_opcode), 32'(m_op));
      chk("result", 32'(mem_result), 32'(m_res));
      chk("store", 32'(mem_store_data), 32'(m_sd));
      chk("rd", 32'(mem_rd_addr), 32'(m_rd));
    end
  end

  task automatic drive(input logic v,
                       input logic [3:0] op,
                       input logic [DW-1:0] res,
                       input logic ov,
                       input logic [DW-1:0] sd,
                       input logic [AW-1:0] rd,
                       input logic rw,
                       input logic mr,
                       input logic mw);
    ex_valid = v; ex_opcode = op; ex_result = res;
    ex_ovfl = ov; ex_store_data = sd; ex_rd_addr = rd;
    ex_reg_write = rw; ex_mem_read = mr;
    ex_mem_write = mw;
    @(negedge clk); #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(mem_valid), 0);
    chk("rst_result", 32'(mem_result), 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_halted", 32'(halted), 0);
    rst_n = 1'b1;

    drive(1, OP_ADD, 16'h0000, 1, 16'h5555, 3, 1, 0, 0);
    chk("add_flags", 32'(flags), 32'b110);
    chk("add_res", 32'(mem_result), 0);
    chk("add_rw", 32'(mem_reg_write), 1);
    drive(1, OP_SUB, 16'h8001, 0, 16'h0, 4, 1, 0, 0);
    chk("sub_flags", 32'(flags), 32'b001);
    drive(1, OP_RED, 16'hFFFE, 0, 16'h0, 4, 1, 0, 0);
    chk("red_flags", 32'(flags), 32'b001);
    drive(1, OP_SUB, 16'h8000, 1, 16'h0, 5, 1, 0, 0);
    chk("sub2_flags", 32'(flags), 32'b011);
    drive(1, OP_XOR, 16'h0000, 0, 16'h0, 6, 1, 0, 0);
    chk("xor_flags", 32'(flags), 32'b111);
    drive(1, OP_PADDSB, 16'h0000, 1, 16'h0, 7, 1, 0, 0);
    chk("paddsb_flags", 32'(flags), 32'b111);

    stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1, OP_ADD, 16'(i * 16'h1111), 0,
            16'h0, 4'(i), 1, 0, 0);
      chk("stall_op", 32'(mem_opcode), 32'(OP_PADDSB));
      chk("stall_rd", 32'(mem_rd_addr), 7);
      chk("stall_flags", 32'(flags), 32'b111);
    end
    flush = 1'b1;
    drive(1, OP_SW, 16'h0040, 0, 16'hBEEF, 0, 0, 0, 1);
    chk("stflush_valid", 32'(mem_valid), 1);
    stall = 1'b0;
    drive(1, OP_SW, 16'h0040, 0, 16'hBEEF, 0, 0, 0, 1);
    chk("flush_valid", 32'(mem_valid), 0);
    chk("flush_mw", 32'(mem_mem_write), 0);
    flush = 1'b0;
    drive(1, OP_SW, 16'h0040, 0, 16'hBEEF, 0, 0, 0, 1);
    chk("sw_data", 32'(mem_store_data), 32'hBEEF);
    drive(1, OP_LW, 16'h0042, 0, 16'h0, 5, 1, 1, 0);
    chk("lw_mr", 32'(mem_mem_read), 1);
    drive(0, OP_ADD, 16'h0000, 1, 16'h0, 2, 1, 0, 0);
    chk("bubble_rw", 32'(mem_reg_write), 0);
    drive(1, OP_SLL, 16'h0001, 0, 16'h0, 2, 1, 0, 0);
    chk("sll_flags", 32'(flags), 32'b011);
    drive(1, OP_ROR, 16'h0000, 0, 16'h0, 2, 1, 0, 0);
    chk("ror_flags", 32'(flags), 32'b111);
    drive(1, OP_SRA, 16'h8000, 0, 16'h0, 2, 1, 0, 0);
    chk("sra_flags", 32'(flags), 32'b011);
    drive(1, OP_LLB, 16'h0000, 1, 16'h0, 2, 1, 0, 0);
    chk("llb_flags", 32'(flags), 32'b011);

    flush = 1'b1;
    drive(1, OP_HLT, 16'h0, 0, 16'h0, 0, 0, 0, 0);
    flush = 1'b0;
    drive(1, OP_ADD, 16'h0007, 0, 16'h0, 1, 1, 0, 0);
    drive(1, OP_ADD, 16'h0007, 0, 16'h0, 1, 1, 0, 0);
    chk("fhlt_halted", 32'(halted), 0);
    chk("fhlt_valid", 32'(mem_valid), 1);
    chk("add7_flags", 32'(flags), 32'b000);

    drive(1, OP_HLT, 16'h0, 0, 16'h0, 0, 1, 0, 0);
    chk("hlt_op", 32'(mem_opcode), 32'(OP_HLT));
    chk("hlt_valid", 32'(mem_valid), 1);
    chk("hlt_rw", 32'(mem_reg_write), 0);
    stall = 1'b1;
    drive(1, OP_ADD, 16'h0, 1, 16'h0, 1, 1, 0, 0);
    chk("drain_st_h", 32'(halted), 0);
    stall = 1'b0;
    drive(1, OP_ADD, 16'h0, 1, 16'h0, 1, 1, 0, 0);
    chk("drain1_h", 32'(halted), 0);
    chk("drain1_v", 32'(mem_valid), 0);
    chk("drain1_f", 32'(flags), 32'b000);
    drive(1, OP_ADD, 16'h0, 1, 16'h0, 1, 1, 0, 0);
    chk("halted1", 32'(halted), 1);
    drive(1, OP_ADD, 16'h0, 1, 16'h0, 1, 1, 0, 0);
    chk("halted2", 32'(halted), 1);
    chk("halted_v", 32'(mem_valid), 0);

    rst_n = 1'b0;
    #1;
    chk("rsth_halted", 32'(halted), 0);
    rst_n = 1'b1;
    drive(1, OP_HLT, 16'h0, 0, 16'h0, 0, 0, 0, 0);
    chk("hlt2_op", 32'(mem_opcode), 32'(OP_HLT));
    drive(1, OP_ADD, 16'h0, 1, 16'h0, 1, 1, 0, 0);
    chk("hlt2_drain", 32'(halted), 0);
    rst_n = 1'b0;
    #1;
    chk("rstd_halted", 32'(halted), 0);
    chk("rstd_op", 32'(mem_opcode), 0);
    chk("rstd_valid", 32'(mem_valid), 0);
    rst_n = 1'b1;
    drive(1, OP_ADD, 16'h8000, 1, 16'h0, 9, 1, 0, 0);
    chk("resume_v", 32'(mem_valid), 1);
    chk("resume_rw", 32'(mem_reg_write), 1);
    chk("resume_f", 32'(flags), 32'b011);
    repeat (3) drive(0, OP_ADD, 16'h0, 0, 16'h0, 0, 0, 0, 0);
    chk("resume_h", 32'(halted), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
